// File: rtl/l2b_sio_pkg.sv
// Shared definitions for the L2-bank-to-SIO response transmitter: header
// field positions, FSM states and the per-halfword bus parity.
package l2b_sio_pkg;

  localparam int unsigned OPES_MSB = 23;
  localparam int unsigned OPES_LSB = 20;
  localparam int unsigned CBA_MSB  = 19;
  localparam int unsigned CBA_LSB  = 16;
  localparam int unsigned TAG_MSB  = 15;
  localparam int unsigned TAG_LSB  = 0;

  localparam int unsigned DATA_BEATS_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_e;

  // Bit 1 covers the upper halfword, bit 0 the lower halfword.
  function automatic logic [1:0] sio_parity(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

endpackage

// File: rtl/l2b_sio_rsp_tx_credit_ctr.sv
// SIO response-buffer credit counter with saturation at the reset value
// and a sticky overflow flag for credits returned while already full.
module l2b_sio_credit_ctr #(
  parameter int unsigned NUM_CREDITS = 4,
  parameter int unsigned CREDIT_W    = 3
) (
  input  logic clk,
  input  logic rst_l,
  input  logic accept,
  input  logic credit_ret,
  output logic credit_nz,
  output logic credit_ovf
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(NUM_CREDITS);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

  logic [CREDIT_W-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case ({accept, credit_ret})
      2'b10: cnt_d = cnt_q - ONE;
      2'b01: begin
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt_q <= FULL;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign credit_nz  = (cnt_q != '0);
  assign credit_ovf = ovf_q;

endmodule

// File: rtl/l2b_sio_rsp_tx.sv
// L2-bank-side SIO response transmitter: one registered header cycle per
// accepted request, followed by DATA_BEATS line words for read responses.
module l2b_sio_rsp_tx
  import l2b_sio_pkg::*;
#(
  parameter int unsigned NUM_CREDITS = 4,
  parameter int unsigned CREDIT_W    = 3,
  parameter int unsigned DATA_BEATS  = DATA_BEATS_DFLT
) (
  input  logic                     iol2clk,
  input  logic                     rst_l,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [3:0]               req_opes,
  input  logic [3:0]               req_cba,
  input  logic [15:0]              req_tag,
  input  logic                     req_has_data,
  input  logic                     req_ue,
  input  logic [DATA_BEATS*32-1:0] req_data,
  input  logic                     sio_l2b_credit,
  output logic                     l2b_sio_ctag_vld,
  output logic [31:0]              l2b_sio_data,
  output logic [1:0]               l2b_sio_parity,
  output logic                     l2b_sio_ue_err,
  output logic                     credit_ovf
);

  localparam int unsigned LINE_W = DATA_BEATS * 32;
  localparam int unsigned BEAT_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                has_data_q, has_data_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                ctag_vld_q, ctag_vld_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          parity_q, parity_d;
  logic                ue_q, ue_d;

  logic                credit_nz;
  logic                accept;
  logic [31:0]         hdr;
  logic [31:0]         line_words [DATA_BEATS];

  assign req_rdy = (state_q == IDLE) && credit_nz;
  assign accept  = req_vld && req_rdy;

  l2b_sio_credit_ctr #(
    .NUM_CREDITS (NUM_CREDITS),
    .CREDIT_W    (CREDIT_W)
  ) u_credit_ctr (
    .clk        (iol2clk),
    .rst_l      (rst_l),
    .accept     (accept),
    .credit_ret (sio_l2b_credit),
    .credit_nz  (credit_nz),
    .credit_ovf (credit_ovf)
  );

  always_comb begin
    hdr                   = '0;
    hdr[OPES_MSB:OPES_LSB] = req_opes;
    hdr[CBA_MSB:CBA_LSB]   = req_cba;
    hdr[TAG_MSB:TAG_LSB]   = req_tag;
  end

  // Word 0 is the most significant word of the line.
  always_comb begin
    for (int unsigned i = 0; i < DATA_BEATS; i++) begin
      line_words[i] = line_q[LINE_W-1-32*i -: 32];
    end
  end

  // Output registers load the value for the state being entered, so the
  // header appears the cycle after accept without a separate capture stage.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    has_data_d = has_data_q;
    line_d     = line_q;
    ctag_vld_d = 1'b0;
    data_d     = '0;
    ue_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = HDR;
          has_data_d = req_has_data;
          if (req_has_data) line_d = req_data;
          ctag_vld_d = 1'b1;
          data_d     = hdr;
          ue_d       = req_ue;
        end
      end
      HDR: begin
        beat_d  = '0;
        state_d = has_data_q ? DATA : IDLE;
      end
      DATA: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DATA) data_d = line_words[beat_d];
    parity_d = sio_parity(data_d);
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      has_data_q <= 1'b0;
      line_q     <= '0;
      ctag_vld_q <= 1'b0;
      data_q     <= '0;
      parity_q   <= '0;
      ue_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      has_data_q <= has_data_d;
      line_q     <= line_d;
      ctag_vld_q <= ctag_vld_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      ue_q       <= ue_d;
    end
  end

  assign l2b_sio_ctag_vld = ctag_vld_q;
  assign l2b_sio_data     = data_q;
  assign l2b_sio_parity   = parity_q;
  assign l2b_sio_ue_err   = ue_q;

endmodule
